// File: rtl/vga_timing_if.sv
// Video timing bus: pixel coordinates plus sync/blank/frame flags for one pixel.
interface vga_timing_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic        frame_start;

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start
  );

  modport slave (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start
  );
endinterface

// File: rtl/vga_timing.sv
// Free-running raster timing generator. Counters and flags are all flops that
// update on the same edge, so coordinate, sync and blank always describe the
// same pixel. Flags are derived from the next-count values for that reason.
module vga_timing #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1
) (
  input logic          pclk,
  input logic          rst_n,
  vga_timing_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Counters are 11 bits wide; larger rasters cannot be represented.
  generate
    if ((H_TOTAL > 2048) || (V_TOTAL > 2048)) begin : g_size_check
      $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 2048");
    end
  endgenerate

  logic [10:0] hcount_r;
  logic [10:0] vcount_r;
  logic        hsync_r;
  logic        vsync_r;
  logic        hblnk_r;
  logic        vblnk_r;
  logic        frame_start_r;

  logic [10:0] hnext_s;
  logic [10:0] vnext_s;
  logic        h_wrap_s;
  logic        v_wrap_s;
  logic        hsync_s;
  logic        vsync_s;
  logic        hblnk_s;
  logic        vblnk_s;
  logic        frame_start_s;

  // Next raster position: h always advances, v advances only on an h wrap.
  always_comb begin
    h_wrap_s = (hcount_r == H_LAST);
    v_wrap_s = h_wrap_s && (vcount_r == V_LAST);
    if (h_wrap_s) begin
      hnext_s = 11'd0;
    end else begin
      hnext_s = hcount_r + 11'd1;
    end
    if (v_wrap_s) begin
      vnext_s = 11'd0;
    end else if (h_wrap_s) begin
      vnext_s = vcount_r + 11'd1;
    end else begin
      vnext_s = vcount_r;
    end
  end

  // Flags for the next position, so they register alongside the counters.
  always_comb begin
    hblnk_s       = (hnext_s >= H_ACT);
    vblnk_s       = (vnext_s >= V_ACT);
    frame_start_s = v_wrap_s;
    if ((hnext_s >= HS_START) && (hnext_s < HS_END)) begin
      hsync_s = HS_POL;
    end else begin
      hsync_s = ~HS_POL;
    end
    if ((vnext_s >= VS_START) && (vnext_s < VS_END)) begin
      vsync_s = VS_POL;
    end else begin
      vsync_s = ~VS_POL;
    end
  end

  // Position and flag registers; reset parks at (0,0) with syncs inactive.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_r      <= 11'd0;
      vcount_r      <= 11'd0;
      hsync_r       <= ~HS_POL;
      vsync_r       <= ~VS_POL;
      hblnk_r       <= 1'b0;
      vblnk_r       <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      hcount_r      <= hnext_s;
      vcount_r      <= vnext_s;
      hsync_r       <= hsync_s;
      vsync_r       <= vsync_s;
      hblnk_r       <= hblnk_s;
      vblnk_r       <= vblnk_s;
      frame_start_r <= frame_start_s;
    end
  end

  assign bus.hcount      = hcount_r;
  assign bus.vcount      = vcount_r;
  assign bus.hsync       = hsync_r;
  assign bus.vsync       = vsync_r;
  assign bus.hblnk       = hblnk_r;
  assign bus.vblnk       = vblnk_r;
  assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: a full-size instance plus two reduced
// rasters (16x12, active-high and active-low syncs) so whole frames fit.
module tb_vga_timing;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
  } vid_t;

  typedef struct packed {
    vid_t d;
    vid_t s;
    vid_t p;
  } exp_t;

  logic pclk = 1'b0;
  logic rst_n = 1'b1;
  bit   done = 1'b0;
  int   n = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  event chk_ev;

  vga_timing_if bus_d ();
  vga_timing_if bus_s ();
  vga_timing_if bus_p ();

  vga_timing u_d (.pclk(pclk), .rst_n(rst_n), .bus(bus_d));

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_s (.pclk(pclk), .rst_n(rst_n), .bus(bus_s));

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_p (.pclk(pclk), .rst_n(rst_n), .bus(bus_p));

  always #5 pclk = ~pclk;

  // Reference position after n edges since reset release, from the raster definition.
  function automatic vid_t model(input int cyc, input int ha, input int hf, input int hsw, input int hbp,
                                 input int va, input int vf, input int vsw, input int vbp,
                                 input bit hp, input bit vp);
    vid_t r;
    int ht, vt, p, h, v;
    ht = ha + hf + hsw + hbp;
    vt = va + vf + vsw + vbp;
    p  = cyc % (ht * vt);
    h  = p % ht;
    v  = p / ht;
    r.h  = 11'(h);
    r.v  = 11'(v);
    r.hb = (h >= ha);
    r.vb = (v >= va);
    r.hs = ((h >= ha + hf) && (h < ha + hf + hsw)) ? hp : ~hp;
    r.vs = ((v >= va + vf) && (v < va + vf + vsw)) ? vp : ~vp;
    r.fs = (p == 0) && (cyc != 0);
    return r;
  endfunction

  function automatic vid_t mk(input int h, input int v, input bit hs, input bit vs,
                              input bit hb, input bit vb, input bit fs);
    vid_t r;
    r = {11'(h), 11'(v), hs, vs, hb, vb, fs};
    return r;
  endfunction

  task automatic chk(input string nm, input vid_t act, input vid_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc-state n=%0d: got h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b fs=%0b, want h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b fs=%0b",
               nm, n, act.h, act.v, act.hs, act.vs, act.hb, act.vb, act.fs,
               exp.h, exp.v, exp.hs, exp.vs, exp.hb, exp.vb, exp.fs);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic push_cur();
    exp_t e;
    e.d = model(n, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1);
    e.s = model(n, 8, 2, 3, 3, 6, 1, 2, 3, 1'b1, 1'b1);
    e.p = model(n, 8, 2, 3, 3, 6, 1, 2, 3, 1'b0, 1'b0);
    sb_q.push_back(e);
  endtask

  task automatic hold_reset();
    repeat (5) begin
      @(posedge pclk);
      #1;
      n = 0;
      push_cur();
    end
  endtask

  task automatic release_reset();
    @(negedge pclk);
    #2;
    rst_n = 1'b1;
    n = 0;
  endtask

  task automatic run(input int k);
    repeat (k) begin
      @(posedge pclk);
      #1;
      n++;
      push_cur();
    end
  endtask

  // Stimulus: reset, long run, asynchronous mid-frame reset, second run.
  initial begin
    #1 rst_n = 1'b0;
    hold_reset();
    release_reset();
    run(3351);
    // Small raster now sits at (7,5); drop reset between edges.
    @(negedge pclk);
    #2;
    rst_n = 1'b0;
    #1;
    n = 0;
    push_cur();
    -> chk_ev;
    hold_reset();
    release_reset();
    run(400);
    @(negedge pclk);
    done = 1'b1;
    repeat (50) @(posedge pclk);
    $display("FAIL watchdog: monitor did not finish, errors=%0d", errors);
    $fatal(1, "monitor timeout");
  end

  // Monitor: pops one expectation per sample and runs the timing measurements.
  initial begin : monitor
    exp_t e;
    vid_t act_d, act_s, act_p;
    int cyc, last_fs, hs_run, hb_run, vs_run, fs_cnt;
    cyc = 0; last_fs = 0; hs_run = 0; hb_run = 0; vs_run = 0; fs_cnt = 0;
    forever begin
      @(negedge pclk or chk_ev);
      act_d = {bus_d.hcount, bus_d.vcount, bus_d.hsync, bus_d.vsync, bus_d.hblnk, bus_d.vblnk, bus_d.frame_start};
      act_s = {bus_s.hcount, bus_s.vcount, bus_s.hsync, bus_s.vsync, bus_s.hblnk, bus_s.vblnk, bus_s.frame_start};
      act_p = {bus_p.hcount, bus_p.vcount, bus_p.hsync, bus_p.vsync, bus_p.hblnk, bus_p.vblnk, bus_p.frame_start};
      if (!rst_n) begin
        cyc = 0; last_fs = 0; hs_run = 0; hb_run = 0; vs_run = 0;
      end else begin
        cyc++;
        if (act_d.hs) hs_run++;
        if (act_d.hb) hb_run++;
        if (act_s.vs) vs_run++;
        if (act_d.h == 11'd1055) begin
          chk_int("d_hsync_width", hs_run, 128);
          chk_int("d_hblnk_width", hb_run, 256);
          hs_run = 0;
          hb_run = 0;
        end
        if (act_s.fs) begin
          fs_cnt++;
          chk_int("s_fs_period", cyc - last_fs, 192);
          chk_int("s_vsync_width", vs_run, 32);
          last_fs = cyc;
          vs_run = 0;
        end
        case (cyc)
          1:    chk("d_first_edge", act_d, mk(1, 0, 0, 0, 0, 0, 0));
          10:   chk("p_hsync_low", act_p, mk(10, 0, 0, 1, 1, 0, 0));
          13:   chk("p_hsync_end", act_p, mk(13, 0, 1, 1, 1, 0, 0));
          111:  chk("s_before_vsync", act_s, mk(15, 6, 0, 0, 1, 1, 0));
          112: begin
            chk("s_vsync_rise", act_s, mk(0, 7, 0, 1, 0, 1, 0));
            chk("p_vsync_low", act_p, mk(0, 7, 1, 0, 0, 1, 0));
          end
          144:  chk("s_vsync_end", act_s, mk(0, 9, 0, 0, 0, 1, 0));
          191:  chk("s_frame_last", act_s, mk(15, 11, 0, 0, 1, 1, 0));
          192:  chk("s_frame_wrap", act_s, mk(0, 0, 0, 0, 0, 0, 1));
          799:  chk("d_last_active", act_d, mk(799, 0, 0, 0, 0, 0, 0));
          800:  chk("d_hblnk_rise", act_d, mk(800, 0, 0, 0, 1, 0, 0));
          839:  chk("d_before_hsync", act_d, mk(839, 0, 0, 0, 1, 0, 0));
          840:  chk("d_hsync_rise", act_d, mk(840, 0, 1, 0, 1, 0, 0));
          967:  chk("d_hsync_last", act_d, mk(967, 0, 1, 0, 1, 0, 0));
          968:  chk("d_hsync_fall", act_d, mk(968, 0, 0, 0, 1, 0, 0));
          1055: chk("d_line_last", act_d, mk(1055, 0, 0, 0, 1, 0, 0));
          1056: chk("d_line_wrap", act_d, mk(0, 1, 0, 0, 0, 0, 0));
          default: ;
        endcase
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_default", act_d, e.d);
        chk("sb_small", act_s, e.s);
        chk("sb_polarity", act_p, e.p);
      end else if (done) begin
        chk_int("s_fs_count", fs_cnt, 19);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Free-running raster timing generator; the first stage of the video pipeline.
- Produces pixel coordinates, sync and blanking for an 800x600@60 Hz raster at 40 MHz pclk.
- Outputs are packed onto the video bus by the bus packer and travel through the draw stages to the sync/blank output stage.
- All outputs are registered and mutually aligned, so downstream stages see coordinate, sync and blank flags for the same pixel in the same cycle.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, hsync active level (1 = active-high)
- VS_POL, 1, vsync active level (1 = active-high)

Ports:
- pclk  input  1  pixel clock; the single clock of the block
- rst_n  input  1  asynchronous, active-low reset
- hcount  output  11  horizontal pixel index, 0..H_TOTAL-1
- vcount  output  11  vertical line index, 0..V_TOTAL-1
- hsync  output  1  horizontal sync at HS_POL level when active
- vsync  output  1  vertical sync at VS_POL level when active
- hblnk  output  1  1 while hcount >= H_ACTIVE
- vblnk  output  1  1 while vcount >= V_ACTIVE
- frame_start  output  1  one-cycle pulse when counts wrap to (0,0)

Behaviour:
- Interface: one clock (pclk); reset is asynchronous and active-low (rst_n).
- Derived constants:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (1056)
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (628)
  - Both must be <= 2048; a violation is reported by an elaboration-time check.
- Reset (rst_n=0, takes effect immediately without a clock edge):
  - hcount=0, vcount=0
  - hblnk=0, vblnk=0, frame_start=0
  - hsync=~HS_POL, vsync=~VS_POL
  - Reset mid-line or mid-frame discards the current position; counting resumes from (0,0) on the first pclk edge after deassertion.
- Counting, every pclk edge:
  - hcount increments; at H_TOTAL-1 it wraps to 0.
  - vcount increments only when hcount wraps; at V_TOTAL-1 with the h wrap, vcount wraps to 0.
  - No enable: the counters never stall.
- Flag generation:
  - Flags are computed combinationally from the next-count values and registered on the same edge as the counters.
  - Result: zero relative latency between counts and flags.
- Flag definitions:
  - hblnk = (hcount >= H_ACTIVE)
  - hsync active when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 840..967
  - vblnk = (vcount >= V_ACTIVE)
  - vsync active when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. 601..604
  - vsync and vblnk change only at the pixel where hcount=0.
- frame_start:
  - Asserted for exactly one cycle, the cycle in which the outputs show hcount=0, vcount=0 after a wrap from (H_TOTAL-1, V_TOTAL-1).
  - Not asserted for the (0,0) state produced by reset.
- Simultaneous h and v wrap: both counters reach 0 on the same edge, and all flags are updated consistently on that edge.
- Internal state is limited to the two counters plus the output registers. No glitches: every output is a flop output.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles, then release -> outputs (0,0), hblnk=vblnk=0, hsync=vsync=0. First edge after release gives hcount=1.
- Line timing: run one line from reset -> hblnk rises at hcount=800 and stays high through 1055. hsync is high exactly for hcount 840..967 (128 cycles). hcount 1055 is followed by hcount=0 with vcount=1.
- Frame timing: run 1056*628 cycles -> vblnk is high for vcount 600..627. vsync is high for vcount 601..604 (4*1056 cycles) and rises at hcount=0. frame_start pulses once, when (1055,627) is followed by (0,0).
- Period check: measure over 3 frames -> frame_start spacing is exactly 663168 cycles. No frame_start in the cycle after reset.
- Mid-frame reset: assert rst_n=0 asynchronously at vcount=300, hcount=517, between edges -> outputs clear immediately (0,0, syncs inactive). Timing after release is identical to the first reset scenario.
- Polarity: instantiate with HS_POL=0, VS_POL=0 -> hsync is low only for hcount 840..967, vsync is low only for vcount 601..604, and the reset value of both is 1.
